// File: rtl/div_hilo_seq.sv
// Multi-cycle DIV sequencer with architectural HI/LO registers for Mini-SRC.
// Operands are registered on start; the combinational divider settles for DIV_LATENCY edges.

module div_comb (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] quotient_c,
    output logic [31:0] remainder_c
);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_mag;
    logic [32:0] rem_mag;

    assign neg_a = a_i[31];
    assign neg_b = b_i[31];
    assign mag_a = neg_a ? 32'(32'd0 - a_i) : a_i;
    assign mag_b = neg_b ? 32'(32'd0 - b_i) : b_i;

    // Restoring division on magnitudes; |INT_MIN| still fits unsigned 32 bits.
    always_comb begin
        rem_mag = '0;
        quo_mag = '0;
        for (int i = 31; i >= 0; i--) begin
            rem_mag = {rem_mag[31:0], mag_a[i]};
            if (rem_mag >= {1'b0, mag_b}) begin
                rem_mag    = 33'(rem_mag - {1'b0, mag_b});
                quo_mag[i] = 1'b1;
            end
        end
    end

    // Quotient truncates toward zero, remainder follows the dividend sign; /0 passes the dividend through.
    always_comb begin
        quotient_c  = '0;
        remainder_c = a_i;
        if (b_i != 32'd0) begin
            quotient_c  = (neg_a ^ neg_b) ? 32'(32'd0 - quo_mag) : quo_mag;
            remainder_c = neg_a ? 32'(32'd0 - rem_mag[31:0]) : rem_mag[31:0];
        end
    end
endmodule

module div_hilo_seq #(
    parameter int unsigned DIV_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;
    logic [31:0]       quotient_c;
    logic [31:0]       remainder_c;

    // Divider sees only the captured operands; its settle window is a multicycle path.
    div_comb u_div (
        .a_i         (op_a_q),
        .b_i         (op_b_q),
        .quotient_c  (quotient_c),
        .remainder_c (remainder_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                // Move-to writes land even when start fires this edge; the result overwrites later.
                if (hi_we) hi_d = hi_in;
                if (lo_we) lo_d = lo_in;
                if (start) begin
                    state_d = S_RUN;
                    op_a_d  = dividend;
                    op_b_d  = divisor;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = CNT_W'(cnt_q - CNT_W'(1));
                end else begin
                    state_d = S_IDLE;
                    lo_d    = quotient_c;
                    hi_d    = remainder_c;
                    dbz_d   = (op_b_q == 32'd0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_div_hilo_seq.sv
// Directed bench for div_hilo_seq with DIV_LATENCY=4 and hand-computed results.

module tb_div_hilo_seq;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    div_hilo_seq #(.DIV_LATENCY(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .hi_in       (hi_in),
        .lo_in       (lo_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start and return the number of sampled busy cycles; leaves time at the done sample.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int n);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        hi_we = 1'b0; lo_we = 1'b0; hi_in = '0; lo_in = '0;
        #12;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        run_div(32'd100, 32'd7, n);
        checks++; if (n !== 4) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=4", n); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", done); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL basic_lo got=%h exp=%h", lo, 32'd14); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL basic_hi got=%h exp=%h", hi, 32'd2); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL basic_lo_hold got=%h exp=%h", lo, 32'd14); end
    endtask

    task automatic test_signed();
        int n;
        run_div(32'hFFFF_FFF9, 32'd2, n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL neg_done got=%b exp=1", done); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL neg_lo got=%h exp=%h", lo, 32'hFFFF_FFFD); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL neg_hi got=%h exp=%h", hi, 32'hFFFF_FFFF); end
        tick();
        run_div(32'd7, 32'hFFFF_FFFE, n);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL negdiv_lo got=%h exp=%h", lo, 32'hFFFF_FFFD); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL negdiv_hi got=%h exp=%h", hi, 32'd1); end
        tick();
    endtask

    task automatic test_div_zero();
        int n;
        run_div(32'd5, 32'd0, n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL dz_done got=%b exp=1", done); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL dz_lo got=%h exp=%h", lo, 32'd0); end
        checks++; if (hi !== 32'd5) begin errors++; $display("FAIL dz_hi got=%h exp=%h", hi, 32'd5); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", div_by_zero); end
        tick();
        tick();
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag_hold got=%b exp=1", div_by_zero); end
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        tick();
        start = 1'b0;
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_flag_clear got=%b exp=0", div_by_zero); end
        n = 0;
        while (busy && n < 20) begin n++; tick(); end
        checks++; if (n !== 4) begin errors++; $display("FAIL dz_next_cycles got=%0d exp=4", n); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL dz_next_lo got=%h exp=%h", lo, 32'd3); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL dz_next_hi got=%h exp=%h", hi, 32'd0); end
        tick();
    endtask

    task automatic test_overflow();
        int n;
        run_div(32'h8000_0000, 32'hFFFF_FFFF, n);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got=%h exp=%h", lo, 32'h8000_0000); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ovf_hi got=%h exp=%h", hi, 32'd0); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz got=%b exp=0", div_by_zero); end
        tick();
    endtask

    task automatic test_busy_ignore();
        int n;
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; dividend = 32'd5; divisor = 32'd1;
        hi_we = 1'b1; hi_in = 32'hDEAD_BEEF;
        lo_we = 1'b1; lo_in = 32'h5555_5555;
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi === 32'hDEAD_BEEF) begin errors++; $display("FAIL busy_hi_write got=%h exp=not %h", hi, 32'hDEAD_BEEF); end
        n = 0;
        while (busy && n < 20) begin n++; tick(); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_ign_done got=%b exp=1", done); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL busy_ign_lo got=%h exp=%h", lo, 32'd14); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL busy_ign_hi got=%h exp=%h", hi, 32'd2); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ign_restart got=%b exp=0", busy); end
        lo_we = 1'b1; lo_in = 32'h0000_1234;
        tick();
        lo_we = 1'b0;
        checks++; if (lo !== 32'h0000_1234) begin errors++; $display("FAIL mtlo_lo got=%h exp=%h", lo, 32'h0000_1234); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL mtlo_hi got=%h exp=%h", hi, 32'd2); end
        hi_we = 1'b1; hi_in = 32'h0BAD_F00D;
        tick();
        hi_we = 1'b0;
        checks++; if (hi !== 32'h0BAD_F00D) begin errors++; $display("FAIL mthi_hi got=%h exp=%h", hi, 32'h0BAD_F00D); end
    endtask

    task automatic test_start_with_write();
        int n;
        start = 1'b1; dividend = 32'd50; divisor = 32'd8;
        hi_we = 1'b1; hi_in = 32'h0000_AAAA;
        tick();
        start = 1'b0; hi_we = 1'b0;
        checks++; if (hi !== 32'h0000_AAAA) begin errors++; $display("FAIL sw_hi_write got=%h exp=%h", hi, 32'h0000_AAAA); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy got=%b exp=1", busy); end
        n = 0;
        while (busy && n < 20) begin n++; tick(); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL sw_lo got=%h exp=%h", lo, 32'd6); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL sw_hi got=%h exp=%h", hi, 32'd2); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        run_div(32'd21, 32'd4, n);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done); end
        start = 1'b1; dividend = 32'd7; divisor = 32'd2;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_low got=%b exp=0", done); end
        checks++; if (lo !== 32'd5 || hi !== 32'd1) begin errors++; $display("FAIL b2b_first_res got=%h/%h exp=%h/%h", lo, hi, 32'd5, 32'd1); end
        n = 0;
        while (busy && n < 20) begin n++; tick(); end
        checks++; if (n !== 4) begin errors++; $display("FAIL b2b_cycles got=%0d exp=4", n); end
        checks++; if (lo !== 32'd3 || hi !== 32'd1) begin errors++; $display("FAIL b2b_second_res got=%h/%h exp=%h/%h", lo, hi, 32'd3, 32'd1); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen_done;
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rmid_hilo got=%h/%h exp=0/0", hi, lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        tick();
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL rmid_no_done got=%0d exp=0", seen_done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rmid_after got=%h/%h exp=0/0", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_start_with_write();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
